// File: rtl/fpu_arbiter.sv
// Two-requester arbiter in front of a shared combinational FPU, with per-opcode latency.
// Define FPU_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of round-robin.
module fpu_arbiter #(
  parameter int unsigned BASE_CYCLES = 1,
  parameter int unsigned FMA_CYCLES  = 2,
  parameter int unsigned DIV_CYCLES  = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [31:0] REQ0_DATA1,
  input  logic [31:0] REQ0_DATA2,
  input  logic [31:0] REQ0_DATA3,
  input  logic [4:0]  REQ0_SELECT,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [31:0] REQ1_DATA1,
  input  logic [31:0] REQ1_DATA2,
  input  logic [31:0] REQ1_DATA3,
  input  logic [4:0]  REQ1_SELECT,
  output logic [31:0] FPU_DATA1,
  output logic [31:0] FPU_DATA2,
  output logic [31:0] FPU_DATA3,
  output logic [4:0]  FPU_SELECT,
  input  logic [31:0] FPU_RESULT,
  output logic        RESP_VALID,
  input  logic        RESP_READY,
  output logic        RESP_ID,
  output logic [31:0] RESP_RESULT,
  output logic        BUSY
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic [31:0] fpu_data1_q, fpu_data1_d;
  logic [31:0] fpu_data2_q, fpu_data2_d;
  logic [31:0] fpu_data3_q, fpu_data3_d;
  logic [4:0]  fpu_select_q, fpu_select_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_result_q, resp_result_d;

  logic        grant_valid;
  logic        grant_id;
  logic        accept;
  logic [31:0] gnt_data1, gnt_data2, gnt_data3;
  logic [4:0]  gnt_select;

  // Execute cycles minus one, so a count of zero means "capture on the next edge".
  function automatic logic [3:0] lat_minus1(input logic [4:0] sel);
    logic [3:0] res;
    if (sel == 5'b00100) begin
      res = 4'(DIV_CYCLES - 1);
    end else if (sel >= 5'b01110 && sel <= 5'b10001) begin
      res = 4'(FMA_CYCLES - 1);
    end else begin
      res = 4'(BASE_CYCLES - 1);
    end
    return res;
  endfunction

  assign grant_valid = REQ0_VALID | REQ1_VALID;
  assign accept      = (state_q == StIdle) & grant_valid;

`ifdef FPU_ARB_FIXED_PRIORITY_EN
  assign grant_id = ~REQ0_VALID;
`else
  logic ptr_q, ptr_d;

  assign grant_id = (REQ0_VALID & REQ1_VALID) ? ptr_q : ~REQ0_VALID;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ~grant_id;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign gnt_data1  = grant_id ? REQ1_DATA1  : REQ0_DATA1;
  assign gnt_data2  = grant_id ? REQ1_DATA2  : REQ0_DATA2;
  assign gnt_data3  = grant_id ? REQ1_DATA3  : REQ0_DATA3;
  assign gnt_select = grant_id ? REQ1_SELECT : REQ0_SELECT;

  assign REQ0_READY = accept & ~grant_id;
  assign REQ1_READY = accept & grant_id;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    fpu_data1_d   = fpu_data1_q;
    fpu_data2_d   = fpu_data2_q;
    fpu_data3_d   = fpu_data3_q;
    fpu_select_d  = fpu_select_q;
    resp_valid_d  = resp_valid_q;
    resp_result_d = resp_result_q;
    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          fpu_data1_d  = gnt_data1;
          fpu_data2_d  = gnt_data2;
          fpu_data3_d  = gnt_data3;
          fpu_select_d = gnt_select;
          owner_d      = grant_id;
          cnt_d        = lat_minus1(gnt_select);
          state_d      = StExec;
        end
      end
      StExec: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_result_d = FPU_RESULT;
          resp_valid_d  = 1'b1;
          state_d       = StResp;
        end
      end
      StResp: begin
        // Returning to idle here (not accepting) leaves one idle cycle between operations.
        if (RESP_READY) begin
          resp_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      owner_q       <= 1'b0;
      fpu_data1_q   <= 32'd0;
      fpu_data2_q   <= 32'd0;
      fpu_data3_q   <= 32'd0;
      fpu_select_q  <= 5'd0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      fpu_data1_q   <= fpu_data1_d;
      fpu_data2_q   <= fpu_data2_d;
      fpu_data3_q   <= fpu_data3_d;
      fpu_select_q  <= fpu_select_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
    end
  end

  assign FPU_DATA1   = fpu_data1_q;
  assign FPU_DATA2   = fpu_data2_q;
  assign FPU_DATA3   = fpu_data3_q;
  assign FPU_SELECT  = fpu_select_q;
  assign RESP_VALID  = resp_valid_q;
  assign RESP_ID     = owner_q;
  assign RESP_RESULT = resp_result_q;
  assign BUSY        = (state_q != StIdle);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: mock FPU, transaction-level grant/latency model, directed and random ops.
module tb_fpu_arbiter;
  localparam int unsigned BaseCycles = 1;
  localparam int unsigned FmaCycles  = 2;
  localparam int unsigned DivCycles  = 4;
`ifdef FPU_ARB_FIXED_PRIORITY_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic        REQ0_READY, REQ1_READY;
  logic [31:0] REQ0_DATA1 = '0, REQ0_DATA2 = '0, REQ0_DATA3 = '0;
  logic [31:0] REQ1_DATA1 = '0, REQ1_DATA2 = '0, REQ1_DATA3 = '0;
  logic [4:0]  REQ0_SELECT = '0, REQ1_SELECT = '0;
  logic [31:0] FPU_DATA1, FPU_DATA2, FPU_DATA3;
  logic [4:0]  FPU_SELECT;
  logic [31:0] FPU_RESULT;
  logic        RESP_VALID, RESP_ID, BUSY;
  logic        RESP_READY = 1'b0;
  logic [31:0] RESP_RESULT;

  fpu_arbiter #(
    .BASE_CYCLES(BaseCycles),
    .FMA_CYCLES (FmaCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .REQ0_VALID (REQ0_VALID),
    .REQ0_READY (REQ0_READY),
    .REQ0_DATA1 (REQ0_DATA1),
    .REQ0_DATA2 (REQ0_DATA2),
    .REQ0_DATA3 (REQ0_DATA3),
    .REQ0_SELECT(REQ0_SELECT),
    .REQ1_VALID (REQ1_VALID),
    .REQ1_READY (REQ1_READY),
    .REQ1_DATA1 (REQ1_DATA1),
    .REQ1_DATA2 (REQ1_DATA2),
    .REQ1_DATA3 (REQ1_DATA3),
    .REQ1_SELECT(REQ1_SELECT),
    .FPU_DATA1  (FPU_DATA1),
    .FPU_DATA2  (FPU_DATA2),
    .FPU_DATA3  (FPU_DATA3),
    .FPU_SELECT (FPU_SELECT),
    .FPU_RESULT (FPU_RESULT),
    .RESP_VALID (RESP_VALID),
    .RESP_READY (RESP_READY),
    .RESP_ID    (RESP_ID),
    .RESP_RESULT(RESP_RESULT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Mock FPU: two real IEEE cases used by directed tests, otherwise an operand scramble.
  function automatic logic [31:0] mock_fpu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [4:0] s);
    if (s == 5'b00001 && a == 32'h3f800000 && b == 32'h40000000) return 32'h40400000;
    if (s == 5'b00100 && a == 32'h40c00000 && b == 32'h40000000) return 32'h40400000;
    return a ^ {b[15:0], b[31:16]} ^ ~c ^ {27'd0, s};
  endfunction

  always_comb FPU_RESULT = mock_fpu(FPU_DATA1, FPU_DATA2, FPU_DATA3, FPU_SELECT);

  int vectors = 0;
  int miscompares = 0;
  int rr_next = 0;

  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [31:0] req_c [2];
  logic [4:0]  req_s [2];

  int          obs_gnt, obs_lat;
  logic [31:0] obs_res, obs_d1;
  logic [4:0]  obs_sel;
  logic        obs_rid, obs_stable, obs_rdy_low, obs_idle_ok;

  function automatic int exp_latency(input logic [4:0] s);
    if (s == 5'd4) return int'(DivCycles);
    if (s >= 5'd14 && s <= 5'd17) return int'(FmaCycles);
    return int'(BaseCycles);
  endfunction

  function automatic int model_grant(input logic v0, input logic v1);
    if (v0 && v1) return FixedPrio ? 0 : rr_next;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    REQ0_VALID = 0;
    REQ1_VALID = 0;
    RESP_READY = 0;
    RESET_N    = 0;
    step;
    step;
    RESET_N = 1;
    rr_next = 0;
    step;
  endtask

  // Drives one request pattern through acceptance, response and release; records observations.
  task automatic transact(input logic v0, input logic v1, input int hold);
    REQ0_VALID = v0; REQ1_VALID = v1;
    REQ0_DATA1 = req_a[0]; REQ0_DATA2 = req_b[0]; REQ0_DATA3 = req_c[0]; REQ0_SELECT = req_s[0];
    REQ1_DATA1 = req_a[1]; REQ1_DATA2 = req_b[1]; REQ1_DATA3 = req_c[1]; REQ1_SELECT = req_s[1];
    #1;
    obs_gnt = REQ1_READY ? (REQ0_READY ? 2 : 1) : (REQ0_READY ? 0 : -1);
    obs_lat = 0;
    obs_rdy_low = 1;
    obs_stable = 1;
    obs_res = '0;
    obs_rid = 0;
    obs_d1 = '0;
    obs_sel = '0;
    step;
    if (obs_gnt == 0 || obs_gnt == 1) begin
      obs_d1  = FPU_DATA1;
      obs_sel = FPU_SELECT;
      while (!RESP_VALID && obs_lat < 20) begin
        if (REQ0_READY || REQ1_READY) obs_rdy_low = 0;
        step;
        obs_lat++;
      end
      if (RESP_VALID) begin
        obs_res = RESP_RESULT;
        obs_rid = RESP_ID;
        for (int i = 0; i < hold; i++) begin
          step;
          if (!RESP_VALID || RESP_RESULT !== obs_res || RESP_ID !== obs_rid ||
              FPU_DATA1 !== obs_d1 || FPU_SELECT !== obs_sel || !BUSY) obs_stable = 0;
          if (REQ0_READY || REQ1_READY) obs_rdy_low = 0;
        end
        RESP_READY = 1;
        step;
        RESP_READY = 0;
      end
    end
    obs_idle_ok = !BUSY && !RESP_VALID;
    REQ0_VALID = 0;
    REQ1_VALID = 0;
  endtask

  task automatic test_reset;
    REQ0_VALID = 0;
    REQ1_VALID = 0;
    #2 RESET_N = 0;
    #1;
    vectors++;
    if ({BUSY, RESP_VALID, RESP_ID, RESP_RESULT, FPU_DATA1, FPU_DATA2, FPU_DATA3, FPU_SELECT}
        !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b rv=%b rid=%b res=%h fpu=%h/%h/%h sel=%h, need all 0",
               BUSY, RESP_VALID, RESP_ID, RESP_RESULT, FPU_DATA1, FPU_DATA2, FPU_DATA3,
               FPU_SELECT);
    end
    step;
    step;
    RESET_N = 1;
    rr_next = 0;
    step;
    vectors++;
    if (BUSY !== 1'b0 || RESP_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b rv=%b, need 0 0", BUSY, RESP_VALID);
    end
    REQ1_VALID = 1;
    #1;
    vectors++;
    if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready1: ready0=%b ready1=%b, need 0 1", REQ0_READY, REQ1_READY);
    end
    REQ1_VALID = 0;
    #1;
    vectors++;
    if (REQ0_READY !== 1'b0 || REQ1_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_none: ready0=%b ready1=%b, need 0 0", REQ0_READY, REQ1_READY);
    end
  endtask

  task automatic test_fadd;
    req_a[0] = 32'h3f800000; req_b[0] = 32'h40000000; req_c[0] = '0; req_s[0] = 5'b00001;
    transact(1, 0, 0);
    vectors++;
    if (obs_gnt != 0 || obs_lat != 1 || obs_res !== 32'h40400000 || obs_rid !== 1'b0 ||
        !obs_idle_ok) begin
      miscompares++;
      $display("FAIL fadd: gnt=%0d lat=%0d res=%h id=%b idle=%b, need 0 1 40400000 0 1",
               obs_gnt, obs_lat, obs_res, obs_rid, obs_idle_ok);
    end
    rr_next = 1;
  endtask

  task automatic test_fdiv;
    req_a[1] = 32'h40c00000; req_b[1] = 32'h40000000; req_c[1] = '0; req_s[1] = 5'b00100;
    transact(0, 1, 0);
    vectors++;
    if (obs_gnt != 1 || obs_lat != 4 || obs_res !== 32'h40400000 || obs_rid !== 1'b1 ||
        obs_sel !== 5'b00100 || !obs_idle_ok) begin
      miscompares++;
      $display("FAIL fdiv: gnt=%0d lat=%0d res=%h id=%b sel=%h, need 1 4 40400000 1 04",
               obs_gnt, obs_lat, obs_res, obs_rid, obs_sel);
    end
    rr_next = 0;
  endtask

  task automatic test_back_to_back;
    int exp_seq [4];
    do_reset;
    for (int k = 0; k < 4; k++) exp_seq[k] = FixedPrio ? 0 : (k % 2);
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 2; r++) begin
        req_a[r] = $urandom; req_b[r] = $urandom; req_c[r] = $urandom; req_s[r] = 5'd0;
      end
      transact(1, 1, 0);
      vectors++;
      if (obs_gnt != exp_seq[k] || obs_rid !== exp_seq[k][0] ||
          obs_res !== mock_fpu(req_a[exp_seq[k]], req_b[exp_seq[k]], req_c[exp_seq[k]], 5'd0))
      begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: gnt=%0d id=%b res=%h, need grant %0d", k, obs_gnt,
                 obs_rid, obs_res, exp_seq[k]);
      end
    end
    rr_next = FixedPrio ? 0 : 0;
  endtask

  task automatic test_resp_hold;
    req_a[0] = $urandom; req_b[0] = $urandom; req_c[0] = $urandom; req_s[0] = 5'b01111;
    req_a[1] = $urandom; req_b[1] = $urandom; req_c[1] = $urandom; req_s[1] = 5'b00010;
    transact(1, 1, 5);
    vectors++;
    if (obs_gnt != rr_next || !obs_stable || !obs_rdy_low || !obs_idle_ok) begin
      miscompares++;
      $display("FAIL resp_hold: gnt=%0d stable=%b ready_low=%b idle=%b, need %0d 1 1 1",
               obs_gnt, obs_stable, obs_rdy_low, obs_idle_ok, rr_next);
    end
    if (!FixedPrio) rr_next = 1 - rr_next;
  endtask

  task automatic test_reset_abort;
    int seen;
    REQ0_DATA1 = 32'h11112222; REQ0_DATA2 = 32'h33334444; REQ0_DATA3 = 32'h55556666;
    REQ0_SELECT = 5'b01110;
    REQ0_VALID = 1;
    step;
    REQ0_VALID = 0;
    #3 RESET_N = 0;
    #1;
    vectors++;
    if ({BUSY, RESP_VALID, RESP_ID, RESP_RESULT, FPU_DATA1, FPU_DATA2, FPU_DATA3, FPU_SELECT}
        !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%b rv=%b res=%h fpu=%h sel=%h, need all 0", BUSY,
               RESP_VALID, RESP_RESULT, FPU_DATA1, FPU_SELECT);
    end
    step;
    RESET_N = 1;
    rr_next = 0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (RESP_VALID || BUSY) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_resp: %0d active cycles after reset, need 0", seen);
    end
    for (int r = 0; r < 2; r++) begin
      req_a[r] = $urandom; req_b[r] = $urandom; req_c[r] = $urandom; req_s[r] = 5'b10101;
    end
    transact(1, 1, 0);
    vectors++;
    if (obs_gnt != 0 || obs_lat != int'(BaseCycles)) begin
      miscompares++;
      $display("FAIL abort_next_grant: gnt=%0d lat=%0d, need 0 %0d", obs_gnt, obs_lat,
               BaseCycles);
    end
    if (!FixedPrio) rr_next = 1;
  endtask

  task automatic test_random;
    logic v0, v1;
    int   eg, hold;
    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      for (int r = 0; r < 2; r++) begin
        req_a[r] = $urandom; req_b[r] = $urandom; req_c[r] = $urandom;
        req_s[r] = 5'($urandom_range(0, 31));
      end
      hold = $urandom_range(0, 3);
      eg = model_grant(v0, v1);
      transact(v0, v1, hold);
      vectors++;
      if (obs_gnt != eg || !obs_idle_ok) begin
        miscompares++;
        $display("FAIL rand_grant[%0d]: gnt=%0d idle=%b, need %0d 1", n, obs_gnt, obs_idle_ok,
                 eg);
      end
      if (eg >= 0) begin
        vectors++;
        if (obs_lat != exp_latency(req_s[eg]) ||
            obs_res !== mock_fpu(req_a[eg], req_b[eg], req_c[eg], req_s[eg]) ||
            obs_rid !== eg[0] || obs_d1 !== req_a[eg] || obs_sel !== req_s[eg] ||
            !obs_stable || !obs_rdy_low) begin
          miscompares++;
          $display("FAIL rand_op[%0d]: lat=%0d res=%h id=%b sel=%h stable=%b, need %0d %h %0d %h",
                   n, obs_lat, obs_res, obs_rid, obs_sel, obs_stable, exp_latency(req_s[eg]),
                   mock_fpu(req_a[eg], req_b[eg], req_c[eg], req_s[eg]), eg, req_s[eg]);
        end
        rr_next = 1 - eg;
      end
    end
  endtask

  initial begin
    test_reset;
    test_fadd;
    test_fdiv;
    test_back_to_back;
    test_resp_hold;
    test_reset_abort;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
